uart_fifo: RTL and testbench

Parametrised synchronous FIFO for the UART datapath: storage, pointer control, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a flush. Sits between the UART receiver and host bus on RX, and between host bus and UART transmitter on TX. It replaces the bare pointer controller plus separate register file with one self-contained block. Unlike that controller, it defines behaviour for simultaneous read/write at the full and empty boundaries.

---
 rtl/uart_fifo.sv | 128 ++++++++++++
 tb/tb_uart_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// Single-clock FIFO for the UART datapath: register-array storage, pointers, occupancy
// count, registered threshold flags, sticky overflow/underflow errors and a flush.
module uart_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  flush_i,
  input  logic                  clr_err_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wrAccept;
  logic rdAccept;
  logic overflowSet;
  logic underflowSet;

  // A write at full is still taken when paired with a read: it lands in the slot being freed.
  always_comb begin
    wrAccept     = wr_i & ~flush_i & (~full_q | rd_i);
    rdAccept     = rd_i & ~flush_i & ~empty_q;
    overflowSet  = wr_i & ~flush_i & full_q & ~rd_i;
    underflowSet = rd_i & ~flush_i & empty_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wrAccept) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rdAccept) begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
      unique case ({wrAccept, rdAccept})
        2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flags are derived from next-count so they move on the same edge as count.
  always_comb begin
    full_d      = (count_d == DEPTH_CNT);
    empty_d     = (count_d == '0);
    af_d        = (count_d >= AF_LVL);
    ae_d        = (count_d <= AE_LVL);
    overflow_d  = (overflow_q  & ~clr_err_i) | overflowSet;
    underflow_d = (underflow_q & ~clr_err_i) | underflowSet;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= (AF_LVL == '0);
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && wrAccept) begin
      mem[wr_ptr_q] <= w_data_i;
    end
  end

  assign r_data_o       = mem[rd_ptr_q];
  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model of the FIFO.
module tb_uart_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk;
  logic          reset;
  logic          wr;
  logic [DW-1:0] wData;
  logic          rd;
  logic [DW-1:0] rData;
  logic          flush;
  logic          clrErr;
  logic          full;
  logic          empty;
  logic          almostFull;
  logic          almostEmpty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue plus the two sticky error bits.
  logic [DW-1:0] modelQ [$];
  logic          modelOv = 1'b0;
  logic          modelUf = 1'b0;
  logic          modelValid = 1'b0;

  uart_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .wr_i          (wr),
    .w_data_i      (wData),
    .rd_i          (rd),
    .r_data_o      (rData),
    .flush_i       (flush),
    .clr_err_i     (clrErr),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (almostFull),
    .almost_empty_o(almostEmpty),
    .count_o       (count),
    .overflow_o    (overflow),
    .underflow_o   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the edge that samples them.
  task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r,
                               input logic f, input logic c, input logic rs);
    wr     = w;
    wData  = d;
    rd     = r;
    flush  = f;
    clrErr = c;
    reset  = rs;
    @(posedge clk);
    #1;
  endtask

  // Model update on each edge from the FIFO rules, not from any pointer bookkeeping.
  always @(posedge clk) begin
    logic wasEmpty;
    logic wasFull;
    logic setOv;
    logic setUf;
    if (reset) begin
      modelQ.delete();
      modelOv    = 1'b0;
      modelUf    = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      setOv    = 1'b0;
      setUf    = 1'b0;
      wasEmpty = (modelQ.size() == 0);
      wasFull  = (modelQ.size() == DEPTH);
      if (flush) begin
        modelQ.delete();
      end else if (wr && rd) begin
        if (wasEmpty) begin
          setUf = 1'b1;
        end else begin
          void'(modelQ.pop_front());
        end
        modelQ.push_back(wData);
      end else if (wr) begin
        if (wasFull) setOv = 1'b1;
        else modelQ.push_back(wData);
      end else if (rd) begin
        if (wasEmpty) setUf = 1'b1;
        else void'(modelQ.pop_front());
      end
      modelOv = (modelOv && !clrErr) || setOv;
      modelUf = (modelUf && !clrErr) || setUf;
    end
  end

  // Compare every output against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("count", 32'(count), 32'(modelQ.size()));
      checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0));
      checkOutput("full", 32'(full), 32'(modelQ.size() == DEPTH));
      checkOutput("almost_full", 32'(almostFull), 32'(modelQ.size() >= AF));
      checkOutput("almost_empty", 32'(almostEmpty), 32'(modelQ.size() <= AE));
      checkOutput("overflow", 32'(overflow), 32'(modelOv));
      checkOutput("underflow", 32'(underflow), 32'(modelUf));
      if (modelQ.size() != 0) begin
        checkOutput("r_data", 32'(rData), 32'(modelQ[0]));
      end
    end
  end

  initial begin
    logic [DW-1:0] drainExp [8];
    int wrPct;
    int rdPct;

    wr = 1'b0; wData = '0; rd = 1'b0; flush = 1'b0; clrErr = 1'b0; reset = 1'b1;

    applyStimulus(0, 8'h00, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 0, 1);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_almost_empty", 32'(almostEmpty), 1);
    checkOutput("rst_almost_full", 32'(almostFull), 0);

    // Fill with 0x11..0x18; head stays 0x11 throughout.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 8'(8'h11 + i), 0, 0, 0, 0);
      checkOutput("fill_count", 32'(count), 32'(i + 1));
      checkOutput("fill_head", 32'(rData), 32'h11);
      checkOutput("fill_af", 32'(almostFull), 32'(i + 1 >= 6));
    end
    checkOutput("fill_full", 32'(full), 1);
    checkOutput("model_fill_size", 32'(modelQ.size()), 8);

    applyStimulus(1, 8'hAA, 0, 0, 0, 0);
    checkOutput("ovf_count", 32'(count), 8);
    checkOutput("ovf_flag", 32'(overflow), 1);
    checkOutput("model_ovf", 32'(modelOv), 1);

    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_data", 32'(rData), 32'(8'h11 + i));
      applyStimulus(0, 8'h00, 1, 0, 0, 0);
    end
    checkOutput("drain_empty", 32'(empty), 1);
    checkOutput("drain_uf", 32'(underflow), 0);

    // Underflow on an empty read, then simultaneous write/read at empty.
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("uf_flag", 32'(underflow), 1);
    checkOutput("uf_count", 32'(count), 0);
    applyStimulus(1, 8'h5C, 1, 0, 0, 0);
    checkOutput("wr_rd_empty_count", 32'(count), 1);
    checkOutput("wr_rd_empty_data", 32'(rData), 32'h5C);
    applyStimulus(0, 8'h00, 0, 0, 1, 0);
    checkOutput("clr_ov", 32'(overflow), 0);
    checkOutput("clr_uf", 32'(underflow), 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);

    // Simultaneous write/read at full keeps count at DEPTH with no overflow.
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'h11 + i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("full_wr_rd_head", 32'(rData), 32'(8'h11 + i));
      applyStimulus(1, 8'h99, 1, 0, 0, 0);
      checkOutput("full_wr_rd_count", 32'(count), 8);
      checkOutput("full_wr_rd_ov", 32'(overflow), 0);
    end
    drainExp = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h99, 8'h99, 8'h99};
    for (int i = 0; i < 8; i++) begin
      checkOutput("full_drain_data", 32'(rData), 32'(drainExp[i]));
      applyStimulus(0, 8'h00, 1, 0, 0, 0);
    end

    // Alternating single write/read pairs carry the pointers across a wrap.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 8'(8'h30 + i), 0, 0, 0, 0);
      checkOutput("wrap_count1", 32'(count), 1);
      checkOutput("wrap_data", 32'(rData), 32'(8'h30 + i));
      applyStimulus(0, 8'h00, 1, 0, 0, 0);
      checkOutput("wrap_count0", 32'(count), 0);
      checkOutput("wrap_ae", 32'(almostEmpty), 1);
    end

    // Flush keeps the error flags and drops the write presented alongside it.
    for (int i = 0; i < 9; i++) applyStimulus(1, 8'(8'h40 + i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("pre_flush_count", 32'(count), 5);
    applyStimulus(1, 8'h77, 0, 1, 0, 0);
    checkOutput("flush_count", 32'(count), 0);
    checkOutput("flush_empty", 32'(empty), 1);
    checkOutput("flush_ov", 32'(overflow), 1);
    checkOutput("model_flush_size", 32'(modelQ.size()), 0);
    applyStimulus(1, 8'h01, 0, 0, 0, 0);
    applyStimulus(1, 8'h02, 0, 0, 0, 0);
    applyStimulus(1, 8'h03, 0, 0, 0, 1);
    checkOutput("midrst_count", 32'(count), 0);
    checkOutput("midrst_empty", 32'(empty), 1);
    checkOutput("midrst_full", 32'(full), 0);
    checkOutput("midrst_ov", 32'(overflow), 0);
    checkOutput("midrst_uf", 32'(underflow), 0);

    // Randomized traffic in phases biased toward filling, draining and balance.
    for (int i = 0; i < 3000; i++) begin
      case (i / 500)
        0, 3:    begin wrPct = 75; rdPct = 30; end
        1, 4:    begin wrPct = 30; rdPct = 75; end
        default: begin wrPct = 55; rdPct = 55; end
      endcase
      applyStimulus($urandom_range(0, 99) < wrPct, 8'($urandom), $urandom_range(0, 99) < rdPct,
                    $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 999) < 3);
    end

    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
